axi_lite_master_ctrl: RTL

// - Single-outstanding AXI-Lite master; sits directly upstream of the AXI slave responder and drives its AR/R/AW/W/B channels.
// - Converts a simple command stream (cmd_*) into one AXI-Lite read or write and returns the result on a response stream (rsp_*).
// - Includes a response watchdog that flags, but never aborts, a slow slave.

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/axi_lite_master_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared state encoding and AXI response codes for the AXI-Lite master
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } axi_mst_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master_ctrl.sv
// rtl/axi_lite_master_ctrl.sv - single-outstanding AXI-Lite master with a non-aborting response watchdog
module axi_lite_master_ctrl
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WDOG_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                timeout_pulse,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   w_data,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   r_data,
    input  logic [1:0]          rresp
);

    // Counter saturates one past the trigger value so the pulse fires exactly once per wait.
    localparam int               WDOG_W    = (WDOG_CYCLES < 1) ? 1 : $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_SAT  = WDOG_W'(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((WDOG_CYCLES < 1) ? 0 : WDOG_CYCLES - 1);
    localparam logic              WDOG_EN   = (WDOG_CYCLES != 0);

    axi_mst_state_e      r_state;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_arvalid;
    logic                r_aw_done;
    logic                r_w_done;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [ADDR_W-1:0]   r_araddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [1:0]          r_rsp_resp;
    logic [WDOG_W-1:0]   r_wdog_cnt;
    logic                r_timeout;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_wdog_wait;

    assign w_aw_hs     = r_awvalid && awready;
    assign w_w_hs      = r_wvalid && wready;
    assign w_aw_done   = r_aw_done || w_aw_hs;
    assign w_w_done    = r_w_done || w_w_hs;
    assign w_wdog_wait = (r_state == WR_RESP) || (r_state == RD_DATA);

    assign cmd_ready     = (r_state == IDLE) && !rst;
    assign rsp_valid     = (r_state == RSP);
    assign bready        = (r_state == WR_RESP);
    assign rready        = (r_state == RD_DATA);
    assign awvalid       = r_awvalid;
    assign wvalid        = r_wvalid;
    assign arvalid       = r_arvalid;
    assign awaddr        = r_awaddr;
    assign araddr        = r_araddr;
    assign w_data        = r_wdata;
    assign wstrb         = r_wstrb;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign timeout_pulse = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_rsp_write <= cmd_write;
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= WR_REQ;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        r_rsp_resp  <= bresp;
                        r_rsp_rdata <= '0;
                        r_state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        r_rsp_rdata <= r_data;
                        r_rsp_resp  <= rresp;
                        r_state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (!w_wdog_wait) begin
                r_wdog_cnt <= '0;
            end else if (WDOG_EN && (r_wdog_cnt != WDOG_SAT)) begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
            end
            r_timeout <= WDOG_EN && w_wdog_wait && (r_wdog_cnt == WDOG_LAST);
        end
    end

endmodule
